id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, 32, datapath width.
REQ-002 SHALL have parameter CNT_W, 16, bubble counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ctrl_id  input  16  decoded control {Branch,Jump,JR,RegWrite,RegDst[1:0],MemRead,MemWrite,MemtoReg[1:0],ALUSrc,ExtOp,ALUOp[3:0]}, MSB first.
REQ-006 SHALL have ports rs_id, rt_id, rd_id, shamt_id  input  5 each  ID register indices and shift amount.
REQ-007 SHALL have ports rdata1_id, rdata2_id, imm_id, pc4_id  input  DATA_W each  operands, extended immediate, PC+4.
REQ-008 SHALL have port flush  input  1  branch/jump resolved taken in EX; squash ID instruction.
REQ-009 SHALL have port mem_hold  input  1  data-memory wait; freeze stage.
REQ-010 SHALL have port ctrl_ex  output  16  registered control, same packing as ctrl_id.
REQ-011 SHALL have ports rs_ex, rt_ex, rd_ex, shamt_ex  output  5 each; rdata1_ex, rdata2_ex, imm_ex, pc4_ex  output  DATA_W each.
REQ-012 SHALL have port stall  output  1  load-use hazard; feeds decoder stall input.
REQ-013 SHALL have port if_id_we  output  1  PC / IF-ID write enable.
REQ-014 SHALL have port bubble_cnt  output  CNT_W  saturating count of inserted bubbles.

Function
REQ-015 stall SHALL be combinational: 1 iff ctrl_ex.MemRead=1, rt_ex!=0, and (rt_ex==rs_id or (rt_ex==rt_id and (ctrl_id.ALUSrc=0 or ctrl_id.MemWrite=1))).
REQ-016 if_id_we SHALL equal !(stall | mem_hold).
REQ-017 Stage SHALL be a 3-state FSM: RUN, HOLD, FLUSHPEND; reset state RUN.
REQ-018 RUN: mem_hold=1 -> HOLD (latch flush into FLUSHPEND path if flush=1); else stay RUN.
REQ-019 HOLD: all outputs frozen; flush=1 seen in HOLD SHALL be remembered; mem_hold=0 -> FLUSHPEND if a flush was remembered, else RUN.
REQ-020 FLUSHPEND: exactly one bubble inserted that cycle, next state RUN (or HOLD if mem_hold=1 again, flush memory retained).
REQ-021 Per-edge priority when not frozen: pending/current flush > stall > capture; flush or stall SHALL load a bubble.
REQ-022 Bubble SHALL clear ctrl_ex and all index/data outputs to zero.
REQ-023 Capture SHALL load all *_id inputs into the matching *_ex outputs; latency exactly one cycle.
REQ-024 Simultaneous flush and stall SHALL produce one bubble, counted once.
REQ-025 bubble_cnt SHALL increment by 1 per inserted bubble, saturating at all-ones, never wrapping.
REQ-026 No register SHALL change while state is HOLD, including bubble_cnt.

Reset
REQ-027 reset=0 SHALL asynchronously force state RUN, flush memory 0, ctrl_ex and all *_ex outputs 0, bubble_cnt 0.
REQ-028 Reset asserted mid-HOLD SHALL discard any remembered flush.
REQ-029 After release, first rising edge SHALL perform normal capture.

Structure
REQ-030 Shared package pipe_pkg SHALL hold DATA_W, ctrl bit-position constants, RegDst/MemtoReg encodings, ALUOp codes, FSM state enum.
REQ-031 Hazard compare (REQ-015) SHALL be sub-module hazard_detect; all flops in id_ex_stage.

Verification
REQ-032 lw $8 in EX (MemRead=1, rt_ex=8), add using rs_id=8 -> stall=1, if_id_we=0, next ctrl_ex=0, bubble_cnt 0->1.
REQ-033 Same with rt_ex=0 -> stall=0, normal capture.
REQ-034 addi (ALUSrc=1) with rt_id=8 after lw $8 -> stall=0; sw with rt_id=8 -> stall=1.
REQ-035 mem_hold=1 for 3 cycles with flush pulsed in cycle 2 -> outputs frozen 3 cycles, then one bubble, bubble_cnt +1.
REQ-036 flush=1 and stall=1 same cycle -> single bubble, bubble_cnt +1.
REQ-037 Preload bubble_cnt to 16'hFFFE, insert 3 bubbles -> 16'hFFFF held; reset=0 mid-HOLD -> all outputs 0 immediately, state RUN.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, control-word bit layout, field encodings
// and the ID/EX stage state encoding.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;

    // Control word layout, MSB first:
    // {Branch,Jump,JR,RegWrite,RegDst[1:0],MemRead,MemWrite,MemtoReg[1:0],ALUSrc,ExtOp,ALUOp[3:0]}
    localparam int CTRL_BRANCH     = 15;
    localparam int CTRL_JUMP       = 14;
    localparam int CTRL_JR         = 13;
    localparam int CTRL_REGWRITE   = 12;
    localparam int CTRL_REGDST_HI  = 11;
    localparam int CTRL_REGDST_LO  = 10;
    localparam int CTRL_MEMREAD    = 9;
    localparam int CTRL_MEMWRITE   = 8;
    localparam int CTRL_MEMTOREG_HI = 7;
    localparam int CTRL_MEMTOREG_LO = 6;
    localparam int CTRL_ALUSRC     = 5;
    localparam int CTRL_EXTOP      = 4;
    localparam int CTRL_ALUOP_HI   = 3;
    localparam int CTRL_ALUOP_LO   = 0;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_PC4 = 2'd2;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_RTYP = 4'd2;
    localparam logic [3:0] ALUOP_AND  = 4'd3;
    localparam logic [3:0] ALUOP_OR   = 4'd4;
    localparam logic [3:0] ALUOP_SLT  = 4'd5;
    localparam logic [3:0] ALUOP_LUI  = 4'd6;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HOLD      = 2'd1,
        ST_FLUSHPEND = 2'd2
    } stage_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
// Purely combinational; no state.
module hazard_detect (
    input  logic       memread_ex,
    input  logic [4:0] rt_ex,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       alusrc_id,
    input  logic       memwrite_id,
    output logic       stall
);

    // rt is only a source when it feeds the ALU or is the store data.
    assign stall = memread_ex && (rt_ex != 5'd0) &&
                   ((rt_ex == rs_id) ||
                    ((rt_ex == rt_id) && (!alusrc_id || memwrite_id)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush squash and memory-wait freeze.
// One-cycle capture latency; HOLD freezes every register, a flush seen meanwhile becomes one bubble.
module id_ex_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       ctrl_id,
    input  logic [4:0]        rs_id,
    input  logic [4:0]        rt_id,
    input  logic [4:0]        rd_id,
    input  logic [4:0]        shamt_id,
    input  logic [DATA_W-1:0] rdata1_id,
    input  logic [DATA_W-1:0] rdata2_id,
    input  logic [DATA_W-1:0] imm_id,
    input  logic [DATA_W-1:0] pc4_id,
    input  logic              flush,
    input  logic              mem_hold,
    output logic [15:0]       ctrl_ex,
    output logic [4:0]        rs_ex,
    output logic [4:0]        rt_ex,
    output logic [4:0]        rd_ex,
    output logic [4:0]        shamt_ex,
    output logic [DATA_W-1:0] rdata1_ex,
    output logic [DATA_W-1:0] rdata2_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [DATA_W-1:0] pc4_ex,
    output logic              stall,
    output logic              if_id_we,
    output logic [CNT_W-1:0]  bubble_cnt
);
    import pipe_pkg::*;

    stage_state_t      state_q, state_d;
    logic              flush_mem_q, flush_mem_d;
    logic [15:0]       ctrl_q, ctrl_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic [DATA_W-1:0] imm_q, imm_d, pc4_q, pc4_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bubble;

    hazard_detect u_hazard (
        .memread_ex  (ctrl_q[CTRL_MEMREAD]),
        .rt_ex       (rt_q),
        .rs_id       (rs_id),
        .rt_id       (rt_id),
        .alusrc_id   (ctrl_id[CTRL_ALUSRC]),
        .memwrite_id (ctrl_id[CTRL_MEMWRITE]),
        .stall       (stall)
    );

    assign if_id_we = !(stall | mem_hold);

    // A flush arriving while the hold starts is deferred to FLUSHPEND rather than
    // squashing now, so it costs exactly one bubble.
    assign bubble = (state_q == ST_FLUSHPEND) ||
                    ((state_q == ST_RUN) && flush && !mem_hold) ||
                    ((state_q != ST_HOLD) && stall);

    always_comb begin
        state_d     = state_q;
        flush_mem_d = flush_mem_q;
        case (state_q)
            ST_RUN: begin
                state_d     = mem_hold ? ST_HOLD : ST_RUN;
                flush_mem_d = mem_hold && flush;
            end
            ST_HOLD: begin
                flush_mem_d = flush_mem_q || flush;
                if (!mem_hold) begin
                    state_d     = (flush_mem_q || flush) ? ST_FLUSHPEND : ST_RUN;
                    flush_mem_d = 1'b0;
                end
            end
            ST_FLUSHPEND: begin
                // The pending flush is consumed by this cycle's bubble.
                state_d     = mem_hold ? ST_HOLD : ST_RUN;
                flush_mem_d = mem_hold && flush;
            end
            default: begin
                state_d     = ST_RUN;
                flush_mem_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        shamt_d  = shamt_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        pc4_d    = pc4_q;
        cnt_d    = cnt_q;
        if (bubble) begin
            ctrl_d   = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            shamt_d  = '0;
            rdata1_d = '0;
            rdata2_d = '0;
            imm_d    = '0;
            pc4_d    = '0;
            cnt_d    = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (state_q != ST_HOLD) begin
            ctrl_d   = ctrl_id;
            rs_d     = rs_id;
            rt_d     = rt_id;
            rd_d     = rd_id;
            shamt_d  = shamt_id;
            rdata1_d = rdata1_id;
            rdata2_d = rdata2_id;
            imm_d    = imm_id;
            pc4_d    = pc4_id;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            flush_mem_q <= 1'b0;
            ctrl_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            shamt_q     <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_mem_q <= flush_mem_d;
            ctrl_q      <= ctrl_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            shamt_q     <= shamt_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            imm_q       <= imm_d;
            pc4_q       <= pc4_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ctrl_ex    = ctrl_q;
    assign rs_ex      = rs_q;
    assign rt_ex      = rt_q;
    assign rd_ex      = rd_q;
    assign shamt_ex   = shamt_q;
    assign rdata1_ex  = rdata1_q;
    assign rdata2_ex  = rdata2_q;
    assign imm_ex     = imm_q;
    assign pc4_ex     = pc4_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use stall, hold/flush, saturation, reset.
module tb_id_ex_stage;

    localparam logic [15:0] C_LW   = 16'h1270;
    localparam logic [15:0] C_ADD  = 16'h1402;
    localparam logic [15:0] C_ADDI = 16'h1030;
    localparam logic [15:0] C_SW   = 16'h0130;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ctrl_id = '0;
    logic [4:0]  rs_id = '0, rt_id = '0, rd_id = '0, shamt_id = '0;
    logic [31:0] rdata1_id = '0, rdata2_id = '0, imm_id = '0, pc4_id = '0;
    logic        flush = 1'b0, mem_hold = 1'b0;
    logic [15:0] ctrl_ex;
    logic [4:0]  rs_ex, rt_ex, rd_ex, shamt_ex;
    logic [31:0] rdata1_ex, rdata2_ex, imm_ex, pc4_ex;
    logic        stall, if_id_we;
    logic [15:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .ctrl_id(ctrl_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id), .shamt_id(shamt_id),
        .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id), .pc4_id(pc4_id),
        .flush(flush), .mem_hold(mem_hold),
        .ctrl_ex(ctrl_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex), .shamt_ex(shamt_ex),
        .rdata1_ex(rdata1_ex), .rdata2_ex(rdata2_ex), .imm_ex(imm_ex), .pc4_ex(pc4_ex),
        .stall(stall), .if_id_we(if_id_we), .bubble_cnt(bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [15:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] im, input logic [31:0] pc);
        ctrl_id = c; rs_id = rs; rt_id = rt; rd_id = rd; shamt_id = sh;
        rdata1_id = r1; rdata2_id = r2; imm_id = im; pc4_id = pc;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_ctrl", {16'h0, ctrl_ex}, 32'h0);
        check("rst_rdata1", rdata1_ex, 32'h0);
        check("rst_cnt", {16'h0, bubble_cnt}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_we", {31'h0, if_id_we}, 32'h1);
        #4 reset = 1'b1;

        // First edge after release captures lw $8
        set_id(C_LW, 5'd2, 5'd8, 5'd0, 5'd0, 32'h100, 32'h55, 32'h4, 32'h40);
        tick();
        check("cap_ctrl", {16'h0, ctrl_ex}, {16'h0, C_LW});
        check("cap_rt", {27'h0, rt_ex}, 32'd8);
        check("cap_rdata1", rdata1_ex, 32'h100);
        check("cap_rdata2", rdata2_ex, 32'h55);
        check("cap_imm", imm_ex, 32'h4);
        check("cap_pc4", pc4_ex, 32'h40);

        // add using rs=8 -> load-use stall, bubble
        set_id(C_ADD, 5'd8, 5'd9, 5'd10, 5'd3, 32'h11, 32'h22, 32'h0, 32'h44);
        #1;
        check("lu_stall", {31'h0, stall}, 32'h1);
        check("lu_we", {31'h0, if_id_we}, 32'h0);
        tick();
        check("lu_bub_ctrl", {16'h0, ctrl_ex}, 32'h0);
        check("lu_bub_rs", {27'h0, rs_ex}, 32'h0);
        check("lu_bub_rdata1", rdata1_ex, 32'h0);
        check("lu_cnt", {16'h0, bubble_cnt}, 32'd1);
        check("lu_stall_clr", {31'h0, stall}, 32'h0);
        check("lu_we_set", {31'h0, if_id_we}, 32'h1);
        tick();
        check("lu_add_ctrl", {16'h0, ctrl_ex}, {16'h0, C_ADD});
        check("lu_add_rd", {27'h0, rd_ex}, 32'd10);
        check("lu_add_shamt", {27'h0, shamt_ex}, 32'd3);

        // lw with rt=0 never stalls
        set_id(C_LW, 5'd2, 5'd0, 5'd0, 5'd0, 32'h200, 32'h0, 32'h8, 32'h48);
        tick();
        set_id(C_ADD, 5'd0, 5'd0, 5'd1, 5'd0, 32'h1, 32'h2, 32'h0, 32'h4C);
        #1;
        check("r0_stall", {31'h0, stall}, 32'h0);
        tick();
        check("r0_ctrl", {16'h0, ctrl_ex}, {16'h0, C_ADD});
        check("r0_cnt", {16'h0, bubble_cnt}, 32'd1);

        // addi reading rt=8 as destination: no stall; sw storing $8: stall
        set_id(C_LW, 5'd2, 5'd8, 5'd0, 5'd0, 32'h300, 32'h0, 32'hC, 32'h50);
        tick();
        set_id(C_ADDI, 5'd3, 5'd8, 5'd0, 5'd0, 32'h5, 32'h0, 32'h7, 32'h54);
        #1;
        check("addi_stall", {31'h0, stall}, 32'h0);
        set_id(C_SW, 5'd3, 5'd8, 5'd0, 5'd0, 32'h5, 32'h66, 32'h10, 32'h54);
        #1;
        check("sw_stall", {31'h0, stall}, 32'h1);
        tick();
        check("sw_bub_ctrl", {16'h0, ctrl_ex}, 32'h0);
        check("sw_cnt", {16'h0, bubble_cnt}, 32'd2);
        tick();
        check("sw_cap_ctrl", {16'h0, ctrl_ex}, {16'h0, C_SW});

        // mem_hold 3 cycles, flush in cycle 2
        set_id(C_ADD, 5'd11, 5'd12, 5'd13, 5'd4, 32'hAAAA0001, 32'hAAAA0002, 32'h0, 32'h58);
        mem_hold = 1'b1;
        #1;
        check("hold_we", {31'h0, if_id_we}, 32'h0);
        tick();
        check("hold_a_rd", {27'h0, rd_ex}, 32'd13);
        set_id(C_ADDI, 5'd14, 5'd15, 5'd0, 5'd0, 32'hBBBB0001, 32'h0, 32'h9, 32'h5C);
        flush = 1'b1;
        tick();
        check("hold_b_rdata1", rdata1_ex, 32'hAAAA0001);
        flush = 1'b0;
        tick();
        check("hold_c_rdata1", rdata1_ex, 32'hAAAA0001);
        check("hold_c_cnt", {16'h0, bubble_cnt}, 32'd2);
        mem_hold = 1'b0;
        tick();
        check("hold_d_ctrl", {16'h0, ctrl_ex}, {16'h0, C_ADD});
        check("hold_d_cnt", {16'h0, bubble_cnt}, 32'd2);
        tick();
        check("fp_bub_ctrl", {16'h0, ctrl_ex}, 32'h0);
        check("fp_bub_rdata1", rdata1_ex, 32'h0);
        check("fp_cnt", {16'h0, bubble_cnt}, 32'd3);
        tick();
        check("fp_next_ctrl", {16'h0, ctrl_ex}, {16'h0, C_ADDI});
        check("fp_next_rs", {27'h0, rs_ex}, 32'd14);
        check("fp_next_cnt", {16'h0, bubble_cnt}, 32'd3);

        // Simultaneous flush and stall: one bubble
        set_id(C_LW, 5'd2, 5'd8, 5'd0, 5'd0, 32'h400, 32'h0, 32'h0, 32'h60);
        tick();
        set_id(C_ADD, 5'd8, 5'd8, 5'd9, 5'd0, 32'h1, 32'h2, 32'h0, 32'h64);
        flush = 1'b1;
        #1;
        check("fs_stall", {31'h0, stall}, 32'h1);
        tick();
        check("fs_ctrl", {16'h0, ctrl_ex}, 32'h0);
        check("fs_cnt", {16'h0, bubble_cnt}, 32'd4);

        // Saturation: drive counter to FFFE with flush bubbles, then 3 more
        repeat (65530) tick();
        check("sat_fffe", {16'h0, bubble_cnt}, 32'h0000FFFE);
        tick();
        check("sat_1", {16'h0, bubble_cnt}, 32'h0000FFFF);
        tick();
        check("sat_2", {16'h0, bubble_cnt}, 32'h0000FFFF);
        tick();
        check("sat_3", {16'h0, bubble_cnt}, 32'h0000FFFF);

        // Reset asserted mid-HOLD with a remembered flush
        flush = 1'b0;
        set_id(C_ADD, 5'd5, 5'd6, 5'd7, 5'd3, 32'hCCCC0001, 32'hCCCC0002, 32'h1, 32'h70);
        mem_hold = 1'b1;
        tick();
        check("mh_cap_ctrl", {16'h0, ctrl_ex}, {16'h0, C_ADD});
        flush = 1'b1;
        tick();
        check("mh_frozen_cnt", {16'h0, bubble_cnt}, 32'h0000FFFF);
        #2 reset = 1'b0;
        #1;
        check("mr_ctrl", {16'h0, ctrl_ex}, 32'h0);
        check("mr_rd", {27'h0, rd_ex}, 32'h0);
        check("mr_rdata1", rdata1_ex, 32'h0);
        check("mr_pc4", pc4_ex, 32'h0);
        check("mr_cnt", {16'h0, bubble_cnt}, 32'h0);
        mem_hold = 1'b0;
        flush = 1'b0;
        #1 reset = 1'b1;
        tick();
        check("post_rst_ctrl", {16'h0, ctrl_ex}, {16'h0, C_ADD});
        check("post_rst_rd", {27'h0, rd_ex}, 32'd7);
        check("post_rst_cnt", {16'h0, bubble_cnt}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
